// File: rtl/vbsme_pkg.sv
// Shared constants for the SAD block-matching datapath: word widths,
// default search-window geometry, tracker state encoding and init value.
package vbsme_pkg;

  localparam int SAD_W    = 32;
  localparam int NUM_ROWS = 49;
  localparam int NUM_COLS = 49;
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int COL_W    = $clog2(NUM_COLS);

  // Tracker states; DONE is a single-cycle result strobe.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Running minimum starts here so any real candidate compares below it.
  localparam logic [SAD_W-1:0] SAD_MAX = {SAD_W{1'b1}};

endpackage

// File: rtl/raster_counter.sv
// Raster-order (row, col) position counter over a NUM_ROWS x NUM_COLS
// candidate grid. Wraps to (0,0) after the last position and flags it.
module raster_counter #(
  parameter int NUM_ROWS = 49,
  parameter int NUM_COLS = 49,
  parameter int ROW_W    = 6,
  parameter int COL_W    = 6
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

  logic [ROW_W-1:0] row_reg, row_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic             row_end, col_end;

  assign row_end = (row_reg == ROW_LAST);
  assign col_end = (col_reg == COL_LAST);

  // Next position: column steps first, row steps when the column wraps.
  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (clr) begin
      row_next = '0;
      col_next = '0;
    end else if (en) begin
      if (col_end) begin
        col_next = '0;
        row_next = row_end ? '0 : (row_reg + ROW_ONE);
      end else begin
        col_next = col_reg + COL_ONE;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      row_reg <= '0;
      col_reg <= '0;
    end else begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  assign row  = row_reg;
  assign col  = col_reg;
  assign last = row_end & col_end;

endmodule

// File: rtl/sad_min_tracker.sv
// Running-minimum tracker at the tail of the SAD adder tree. Keeps the
// best SAD of a block search with its (row, col) motion vector, drives the
// SAD mux select, and pulses Done once the final candidate is folded in.
module sad_min_tracker #(
  parameter int SAD_W    = vbsme_pkg::SAD_W,
  parameter int NUM_ROWS = vbsme_pkg::NUM_ROWS,
  parameter int NUM_COLS = vbsme_pkg::NUM_COLS,
  parameter int ROW_W    = vbsme_pkg::ROW_W,
  parameter int COL_W    = vbsme_pkg::COL_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             InValid,
  input  logic [SAD_W-1:0] InSAD,
  output logic             Sel,
  output logic [SAD_W-1:0] MinSAD,
  output logic [ROW_W-1:0] MinRow,
  output logic [COL_W-1:0] MinCol,
  output logic             Busy,
  output logic             Done
);

  import vbsme_pkg::*;

  localparam logic [SAD_W-1:0] SAD_INIT = '1;

  state_t           state_reg, state_next;
  logic             first_reg;
  logic [SAD_W-1:0] min_sad_reg;
  logic [ROW_W-1:0] min_row_reg;
  logic [COL_W-1:0] min_col_reg;

  logic             init;    // start of a new search (from IDLE or DONE)
  logic             accept;  // a candidate is consumed this cycle
  logic             take;    // the candidate becomes the new minimum
  logic [ROW_W-1:0] cnt_row;
  logic [COL_W-1:0] cnt_col;
  logic             cnt_last;

  assign init   = ((state_reg == IDLE) || (state_reg == DONE)) && Start;
  assign accept = (state_reg == SCAN) && InValid;
  // Strict less-than keeps the earliest candidate on ties; the first
  // candidate always wins so the coordinates are never stale.
  assign take   = accept && (first_reg || (InSAD < min_sad_reg));

  raster_counter #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS),
    .ROW_W    (ROW_W),
    .COL_W    (COL_W)
  ) u_raster_counter (
    .clk  (Clk),
    .srst (Rst),
    .clr  (init),
    .en   (accept),
    .row  (cnt_row),
    .col  (cnt_col),
    .last (cnt_last)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a search ends on the accept of the last position.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Start) state_next = SCAN;
      SCAN:    if (accept && cnt_last) state_next = DONE;
      DONE:    state_next = Start ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore status outputs plus the combinational mux select.
  always_comb begin
    Busy = (state_reg == SCAN);
    Done = (state_reg == DONE);
    Sel  = take;
  end

  // Minimum registers: re-armed on a new search, updated on every new best.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      min_sad_reg <= SAD_INIT;
      min_row_reg <= '0;
      min_col_reg <= '0;
      first_reg   <= 1'b0;
    end else if (init) begin
      min_sad_reg <= SAD_INIT;
      first_reg   <= 1'b1;
    end else if (take) begin
      min_sad_reg <= InSAD;
      min_row_reg <= cnt_row;
      min_col_reg <= cnt_col;
      first_reg   <= 1'b0;
    end
  end

  assign MinSAD = min_sad_reg;
  assign MinRow = min_row_reg;
  assign MinCol = min_col_reg;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Self-checking bench for sad_min_tracker on a 3x4 window: a table of
// directed searches, hand-written reset/back-to-back sequences and
// randomized searches checked against an argmin reference model.
module tb_sad_min_tracker;

  localparam int NR    = 3;
  localparam int NC    = 4;
  localparam int NCAND = NR * NC;
  localparam int SW    = 32;
  localparam int RW    = 6;
  localparam int CW    = 6;

  logic          Clk = 1'b0;
  logic          Rst, Start, InValid;
  logic [SW-1:0] InSAD;
  logic          Sel, Busy, Done;
  logic [SW-1:0] MinSAD;
  logic [RW-1:0] MinRow;
  logic [CW-1:0] MinCol;

  always #5 Clk = ~Clk;

  sad_min_tracker #(
    .SAD_W    (SW),
    .NUM_ROWS (NR),
    .NUM_COLS (NC),
    .ROW_W    (RW),
    .COL_W    (CW)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .InValid (InValid),
    .InSAD   (InSAD),
    .Sel     (Sel),
    .MinSAD  (MinSAD),
    .MinRow  (MinRow),
    .MinCol  (MinCol),
    .Busy    (Busy),
    .Done    (Done)
  );

  typedef struct packed {
    logic [0:NCAND-1][31:0] sads;
    logic [0:NCAND-1]       exp_sel;
    logic [31:0]            exp_min;
    logic [5:0]             exp_row;
    logic [5:0]             exp_col;
    int                     stall_at;
    int                     stall_len;
    bit                     noise;
  } vec_t;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] cand [NCAND];
  vec_t        tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Best of cand[0..upto]; strict less-than means the earliest index wins.
  function automatic void prefix_min(input int upto, output logic [31:0] mn, output int idx);
    mn  = cand[0];
    idx = 0;
    for (int i = 1; i <= upto; i++) begin
      if (cand[i] < mn) begin
        mn  = cand[i];
        idx = i;
      end
    end
  endfunction

  // Reference: a candidate is selected if it is the first or beats every earlier one.
  function automatic void model(output logic [0:NCAND-1] sel, output logic [31:0] mn,
                                output int r, output int c);
    logic [31:0] m;
    int          j;
    sel    = '0;
    sel[0] = 1'b1;
    for (int i = 1; i < NCAND; i++) begin
      prefix_min(i - 1, m, j);
      sel[i] = (cand[i] < m);
    end
    prefix_min(NCAND - 1, mn, j);
    r = j / NC;
    c = j % NC;
  endfunction

  // Start a search (from IDLE or DONE), feed cand[] with an optional stall,
  // and finish in the DONE cycle, one cycle after the final accept.
  task automatic feed(input string tag, input int stall_at, input int stall_len, input bit noise,
                      input logic [0:NCAND-1] exp_sel, input logic [31:0] exp_min,
                      input int exp_row, input int exp_col);
    logic [31:0] m;
    int          j;
    Start   = 1'b1;
    InValid = noise;
    InSAD   = 32'd1;
    tick();
    Start   = 1'b0;
    InValid = 1'b0;
    check({tag, " busy@start"}, 32'(Busy), 32'd1);
    check({tag, " minsad@start"}, MinSAD, 32'hFFFF_FFFF);
    check({tag, " done@start"}, 32'(Done), 32'd0);
    for (int i = 0; i < NCAND; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          InValid = 1'b0;
          Start   = noise;
          InSAD   = $urandom;
          #1;
          check($sformatf("%s sel-stall%0d", tag, k), 32'(Sel), 32'd0);
          tick();
          Start = 1'b0;
        end
      end
      InValid = 1'b1;
      InSAD   = cand[i];
      #1;
      check($sformatf("%s sel[%0d]", tag, i), 32'(Sel), 32'(exp_sel[i]));
      tick();
      InValid = 1'b0;
      prefix_min(i, m, j);
      check($sformatf("%s minsad[%0d]", tag, i), MinSAD, m);
      check($sformatf("%s minrow[%0d]", tag, i), 32'(MinRow), 32'(j / NC));
      check($sformatf("%s mincol[%0d]", tag, i), 32'(MinCol), 32'(j % NC));
    end
    check({tag, " done"}, 32'(Done), 32'd1);
    check({tag, " busy@done"}, 32'(Busy), 32'd0);
    check({tag, " sel@done"}, 32'(Sel), 32'd0);
    check({tag, " final minsad"}, MinSAD, exp_min);
    check({tag, " final row"}, 32'(MinRow), 32'(exp_row));
    check({tag, " final col"}, 32'(MinCol), 32'(exp_col));
    $display("search %s: min=%0d at (%0d,%0d)", tag, MinSAD, MinRow, MinCol);
  endtask

  // Leave DONE for IDLE and confirm the pulse ends and results hold.
  task automatic to_idle(input string tag, input logic [31:0] exp_min);
    tick();
    check({tag, " done@idle"}, 32'(Done), 32'd0);
    check({tag, " hold minsad"}, MinSAD, exp_min);
  endtask

  initial begin
    logic [0:NCAND-1] rsel;
    logic [31:0]      rmin;
    int               rr, rc, sa, sl;

    tbl[0] = '{sads: {32'd100, 32'd90, 32'd95, 32'd80, 32'd85, 32'd70,
                      32'd75, 32'd60, 32'd65, 32'd50, 32'd55, 32'd40},
               exp_sel: 12'b1101_0101_0101, exp_min: 32'd40, exp_row: 6'd2, exp_col: 6'd3,
               stall_at: -1, stall_len: 0, noise: 1'b0};
    tbl[1] = '{sads: {32'hFFFF_FFFF, 32'd50, 32'd30, 32'd50, 32'd50, 32'd30,
                      32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50},
               exp_sel: 12'b1110_0000_0000, exp_min: 32'd30, exp_row: 6'd0, exp_col: 6'd2,
               stall_at: -1, stall_len: 0, noise: 1'b0};
    tbl[2] = tbl[0];
    tbl[2].stall_at  = 6;
    tbl[2].stall_len = 3;
    tbl[2].noise     = 1'b1;
    tbl[3] = '{sads: {NCAND{32'd5}},
               exp_sel: 12'b1000_0000_0000, exp_min: 32'd5, exp_row: 6'd0, exp_col: 6'd0,
               stall_at: -1, stall_len: 0, noise: 1'b0};

    // Reset: two cycles, then check the idle state with InValid driven.
    Rst = 1'b1; Start = 1'b0; InValid = 1'b0; InSAD = '0;
    tick();
    tick();
    Rst     = 1'b0;
    InValid = 1'b1;
    #1;
    check("reset minsad", MinSAD, 32'hFFFF_FFFF);
    check("reset minrow", 32'(MinRow), 32'd0);
    check("reset mincol", 32'(MinCol), 32'd0);
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset sel", 32'(Sel), 32'd0);
    // InValid while idle must not be consumed.
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("idle busy%0d", k), 32'(Busy), 32'd0);
      check($sformatf("idle sel%0d", k), 32'(Sel), 32'd0);
    end
    InValid = 1'b0;

    // Directed table.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NCAND; i++) cand[i] = tbl[t].sads[i];
      feed($sformatf("tbl%0d", t), tbl[t].stall_at, tbl[t].stall_len, tbl[t].noise,
           tbl[t].exp_sel, tbl[t].exp_min, int'(tbl[t].exp_row), int'(tbl[t].exp_col));
      to_idle($sformatf("tbl%0d", t), tbl[t].exp_min);
    end

    // Back-to-back: second Start lands in the DONE cycle of the first.
    for (int i = 0; i < NCAND; i++) cand[i] = tbl[0].sads[i];
    feed("b2b-a", -1, 0, 1'b0, tbl[0].exp_sel, 32'd40, 2, 3);
    cand = '{32'd20, 32'd15, 32'd30, 32'd25, 32'd7, 32'd9,
             32'd8, 32'd7, 32'd12, 32'd40, 32'd7, 32'd10};
    feed("b2b-b", -1, 0, 1'b0, 12'b1100_1000_0000, 32'd7, 1, 0);
    to_idle("b2b-b", 32'd7);

    // Reset after 5 accepts aborts the search.
    for (int i = 0; i < NCAND; i++) cand[i] = tbl[0].sads[i];
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      InValid = 1'b1;
      InSAD   = cand[i];
      tick();
    end
    InValid = 1'b0;
    Rst     = 1'b1;
    tick();
    Rst = 1'b0;
    check("abort busy", 32'(Busy), 32'd0);
    check("abort done", 32'(Done), 32'd0);
    check("abort minsad", MinSAD, 32'hFFFF_FFFF);
    check("abort minrow", 32'(MinRow), 32'd0);
    check("abort mincol", 32'(MinCol), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort no-done%0d", k), 32'(Done), 32'd0);
    end
    for (int i = 0; i < NCAND; i++) cand[i] = tbl[1].sads[i];
    feed("after-abort", -1, 0, 1'b0, tbl[1].exp_sel, 32'd30, 0, 2);
    to_idle("after-abort", 32'd30);

    // Randomized searches against the reference model.
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < NCAND; i++)
        cand[i] = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 40));
      model(rsel, rmin, rr, rc);
      sa = $urandom_range(0, NCAND - 1);
      sl = $urandom_range(0, 3);
      feed($sformatf("rnd%0d", s), sa, sl, 1'($urandom_range(0, 1)), rsel, rmin, rr, rc);
      if ($urandom_range(0, 1) == 1) to_idle($sformatf("rnd%0d", s), rmin);
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
